// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the main-memory responder.
//   - mem_state_e     : responder states (CLEAR only reachable with MEM_CLEAR_EN)
//   - MEM_ADDR_W/MEM_DATA_W/MEM_LATENCY : default geometry and access latency
//   - block layout    : a 16-bit block holds two 8-bit words; offset 0 is the
//                       low byte, offset 1 the high byte (same as the cache)
package mem_pkg;

  localparam int MEM_ADDR_W  = 7;
  localparam int MEM_DATA_W  = 16;
  localparam int MEM_LATENCY = 100;

  localparam int WORD_W          = 8;
  localparam int WORDS_PER_BLOCK = 2;
  localparam int WORD0_LSB       = 0;
  localparam int WORD1_LSB       = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    CLEAR  = 2'd3
  } mem_state_e;

  // Extract one word of a block by its offset within the block.
  function automatic logic [WORD_W-1:0] block_word(
    input logic [MEM_DATA_W-1:0] blk,
    input logic                  off
  );
    return off ? blk[WORD1_LSB +: WORD_W] : blk[WORD0_LSB +: WORD_W];
  endfunction

endpackage

// File: rtl/mem_array.sv
// mem_array: single-port block storage.
//   clk   : clock, write and read both happen on the rising edge
//   rst   : asynchronous active-low reset, clears only the read register
//   we    : write wdata into mem[addr]
//   re    : load mem[addr] into rdata
//   addr  : block address
//   wdata : block to write
//   rdata : registered read data, holds until the next re
// Storage contents are never reset.
module mem_array
  import mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: memory end of the cache block bus. Accepts one block read or
// write per handshake, stalls the requester for LATENCY+1 cycles, then commits
// the write or returns the read block.
//   clk        : clock
//   rst        : asynchronous active-low reset
//   read/write : request lines, held until busy_wait falls; both high is ignored
//   address    : block address, captured on accept
//   write_data : block to write, captured on accept
//   read_data  : last block read (0 after reset), unaffected by writes
//   busy_wait  : stall; combinational from the request in IDLE so the
//                requester never sees a stale low in the request cycle
// Build option: MEM_CLEAR_EN -- after reset, zero every block (one per cycle)
// with busy_wait held high before the first request is accepted.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W  = MEM_ADDR_W,
  parameter int DATA_W  = MEM_DATA_W,
  parameter int LATENCY = MEM_LATENCY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              busy_wait
);

  localparam int              CNT_W    = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

`ifdef MEM_CLEAR_EN
  localparam mem_state_e RST_STATE = CLEAR;
`else
  localparam mem_state_e RST_STATE = IDLE;
`endif

  mem_state_e        state;
  logic [CNT_W-1:0]  cnt;
  logic              op_wr_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] wdata_p0;

  logic              req_vld;
  logic              commit;
  logic              arr_we;
  logic              arr_re;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_wdata;

`ifdef MEM_CLEAR_EN
  logic [ADDR_W-1:0] clr_addr;
`endif

  assign req_vld = read ^ write;
  assign commit  = (state == ACCESS) && (cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RST_STATE;
      cnt      <= '0;
      op_wr_p0 <= 1'b0;
`ifdef MEM_CLEAR_EN
      clr_addr <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_vld) begin
            state    <= ACCESS;
            cnt      <= CNT_LOAD;
            op_wr_p0 <= write;
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            state <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        CLEAR: begin
`ifdef MEM_CLEAR_EN
          // clr_addr wraps back to 0 on the last block
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == '1) begin
            state <= IDLE;
          end
`else
          state <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---- accept stage: request operands captured into _p0 ----
  always_ff @(posedge clk) begin
    if ((state == IDLE) && req_vld) begin
      addr_p0  <= address;
      wdata_p0 <= write_data;
    end
  end

  // ---- commit stage: _p0 operands drive the array on the last access edge ----
  always_comb begin
    arr_we    = commit & op_wr_p0;
    arr_re    = commit & ~op_wr_p0;
    arr_addr  = addr_p0;
    arr_wdata = wdata_p0;
`ifdef MEM_CLEAR_EN
    if (state == CLEAR) begin
      arr_we    = 1'b1;
      arr_re    = 1'b0;
      arr_addr  = clr_addr;
      arr_wdata = '0;
    end
`endif
  end

  always_comb begin
    busy_wait = 1'b0;
    case (state)
      IDLE:    busy_wait = req_vld;
      ACCESS:  busy_wait = 1'b1;
      CLEAR:   busy_wait = 1'b1;
      default: busy_wait = 1'b0;
    endcase
    // Stall drops as soon as reset asserts, even with a request still held.
    if (!rst) begin
      busy_wait = 1'b0;
    end
  end

  mem_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_array (
    .clk  (clk),
    .rst  (rst),
    .we   (arr_we),
    .re   (arr_re),
    .addr (arr_addr),
    .wdata(arr_wdata),
    .rdata(read_data)
  );

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  localparam int AW       = 7;
  localparam int DW       = 16;
  localparam int LAT      = 4;
  localparam int LAT_LONG = 100;
  localparam int DEPTH    = 1 << AW;
  localparam int LIMIT    = 1000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rd = 1'b0, wr = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata;
  logic          busy;
  logic          rd2 = 1'b0, wr2 = 1'b0;
  logic [AW-1:0] addr2 = '0;
  logic [DW-1:0] wdata2 = '0;
  logic [DW-1:0] rdata2;
  logic          busy2;

  int checks = 0;
  int errors = 0;

  // Reference model: block contents, which blocks hold a defined value,
  // and the value read_data should currently show.
  logic [DW-1:0] mdl [DEPTH];
  bit            known [DEPTH];
  logic [DW-1:0] last_rd;
  bit            last_known;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .read(rd), .write(wr), .address(addr),
    .write_data(wdata), .read_data(rdata), .busy_wait(busy)
  );

  mem_responder #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(LAT_LONG)) dut_long (
    .clk(clk), .rst(rst), .read(rd2), .write(wr2), .address(addr2),
    .write_data(wdata2), .read_data(rdata2), .busy_wait(busy2)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic model_reset();
    last_rd    = '0;
    last_known = 1'b1;
`ifdef MEM_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) begin
      mdl[i]   = '0;
      known[i] = 1'b1;
    end
`endif
  endtask

  task automatic wait_clear();
`ifdef MEM_CLEAR_EN
    repeat (DEPTH + 2) @(posedge clk);
`endif
  endtask

  // One full handshake on the LATENCY=4 instance. nb = cycles busy_wait was
  // seen high starting with the request cycle; q = read_data in the first
  // cycle busy_wait is low.
  task automatic access(input bit is_wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output int nb,
                        output logic [DW-1:0] q);
    @(posedge clk);
    #1;
    rd = !is_wr; wr = is_wr; addr = a; wdata = d;
    nb = 0;
    @(negedge clk);
    while (busy === 1'b1 && nb < LIMIT) begin
      nb++;
      @(negedge clk);
    end
    q = rdata;
    rd = 1'b0; wr = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (rdata !== 16'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0000", rdata); end
    checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL reset_busy_long: got %b expected 0", busy2); end
    checks++; if (rdata2 !== 16'h0) begin errors++; $display("FAIL reset_rdata_long: got %h expected 0000", rdata2); end
    @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
    @(negedge clk);
`ifdef MEM_CLEAR_EN
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL post_reset_busy: got %b expected 1", busy); end
`else
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b expected 0", busy); end
`endif
    wait_clear();
  endtask

`ifdef MEM_CLEAR_EN
  task automatic test_clear();
    int nb;
    @(posedge clk);
    #1 rst = 1'b0;
    rd = 1'b1; addr = 7'h7F;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
    nb = 0;
    @(negedge clk);
    while (busy === 1'b1 && nb < LIMIT) begin
      nb++;
      @(negedge clk);
    end
    checks++; if (nb != DEPTH + LAT + 1) begin errors++; $display("FAIL clear_busy_len: got %0d expected %0d", nb, DEPTH + LAT + 1); end
    checks++; if (rdata !== mdl[7'h7F]) begin errors++; $display("FAIL clear_rdata: got %h expected %h", rdata, mdl[7'h7F]); end
    rd = 1'b0;
    last_rd = mdl[7'h7F];
    wait_clear();
  endtask
`endif

  task automatic test_write_read();
    int nb;
    logic [DW-1:0] q;
    access(1'b1, 7'h05, 16'hA55A, nb, q);
    checks++; if (nb != LAT + 1) begin errors++; $display("FAIL wr_busy_len: got %0d expected %0d", nb, LAT + 1); end
    checks++; if (q !== last_rd) begin errors++; $display("FAIL wr_keeps_rdata: got %h expected %h", q, last_rd); end
    mdl[7'h05] = 16'hA55A; known[7'h05] = 1'b1;
    access(1'b0, 7'h05, 16'h0000, nb, q);
    checks++; if (nb != LAT + 1) begin errors++; $display("FAIL rd_busy_len: got %0d expected %0d", nb, LAT + 1); end
    checks++; if (q !== mdl[7'h05]) begin errors++; $display("FAIL rd_data: got %h expected %h", q, mdl[7'h05]); end
    last_rd = mdl[7'h05]; last_known = 1'b1;
  endtask

  task automatic test_latency_long();
    int nb;
    @(posedge clk);
    #1;
    rd2 = 1'b1; addr2 = AW'($urandom_range(0, DEPTH - 1));
    nb = 0;
    @(negedge clk);
    while (busy2 === 1'b1 && nb < LIMIT) begin
      nb++;
      @(negedge clk);
    end
    rd2 = 1'b0;
    checks++; if (nb != LAT_LONG + 1) begin errors++; $display("FAIL long_busy_len: got %0d expected %0d", nb, LAT_LONG + 1); end
  endtask

  task automatic test_illegal();
    int nb;
    logic [DW-1:0] q;
    @(posedge clk);
    #1;
    rd = 1'b1; wr = 1'b1; addr = 7'h05; wdata = 16'h0000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL illegal_busy: cycle %0d got %b expected 0", i, busy); end
    end
    @(posedge clk);
    #1 rd = 1'b0; wr = 1'b0;
    access(1'b0, 7'h05, 16'h0000, nb, q);
    checks++; if (q !== mdl[7'h05]) begin errors++; $display("FAIL illegal_no_write: got %h expected %h", q, mdl[7'h05]); end
    last_rd = mdl[7'h05]; last_known = 1'b1;
  endtask

  task automatic test_mid_change();
    int nb;
    logic [DW-1:0] q;
    logic [DW-1:0] d;
    access(1'b1, 7'h10, 16'h3C3C, nb, q);
    mdl[7'h10] = 16'h3C3C; known[7'h10] = 1'b1;
    d = DW'($urandom);
    if (d == 16'hFFFF) d = 16'h0001;
    @(posedge clk);
    #1;
    wr = 1'b1; rd = 1'b0; addr = 7'h05; wdata = d;
    nb = 0;
    @(negedge clk);
    while (busy === 1'b1 && nb < LIMIT) begin
      nb++;
      if (nb == 2) begin
        addr = 7'h10; wdata = 16'hFFFF;
      end
      @(negedge clk);
    end
    wr = 1'b0;
    checks++; if (nb != LAT + 1) begin errors++; $display("FAIL mid_busy_len: got %0d expected %0d", nb, LAT + 1); end
    mdl[7'h05] = d;
    access(1'b0, 7'h05, 16'h0000, nb, q);
    checks++; if (q !== mdl[7'h05]) begin errors++; $display("FAIL mid_captured: got %h expected %h", q, mdl[7'h05]); end
    access(1'b0, 7'h10, 16'h0000, nb, q);
    checks++; if (q !== mdl[7'h10]) begin errors++; $display("FAIL mid_untouched: got %h expected %h", q, mdl[7'h10]); end
    last_rd = mdl[7'h10]; last_known = 1'b1;
  endtask

  task automatic test_reset_access();
    int nb;
    logic [DW-1:0] q;
    access(1'b1, 7'h20, 16'h0BEE, nb, q);
    mdl[7'h20] = 16'h0BEE; known[7'h20] = 1'b1;
    @(posedge clk);
    #1;
    wr = 1'b1; rd = 1'b0; addr = 7'h20; wdata = 16'h1234;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    checks++; if (rdata !== 16'h0) begin errors++; $display("FAIL rst_mid_rdata: got %h expected 0000", rdata); end
    wr = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
    wait_clear();
    access(1'b0, 7'h20, 16'h0000, nb, q);
    checks++; if (q !== mdl[7'h20]) begin errors++; $display("FAIL rst_mid_dropped: got %h expected %h", q, mdl[7'h20]); end
    last_rd = mdl[7'h20]; last_known = 1'b1;
  endtask

  task automatic test_back_to_back();
    int nb;
    logic [DW-1:0] q;
    access(1'b1, 7'h05, 16'h5AA5, nb, q);
    mdl[7'h05] = 16'h5AA5; known[7'h05] = 1'b1;
    @(posedge clk);
    #1;
    rd = 1'b1; addr = 7'h05;
    nb = 0;
    @(negedge clk);
    while (busy === 1'b1 && nb < LIMIT) begin
      nb++;
      @(negedge clk);
    end
    checks++; if (nb != LAT + 1) begin errors++; $display("FAIL b2b_first_len: got %0d expected %0d", nb, LAT + 1); end
    checks++; if (rdata !== mdl[7'h05]) begin errors++; $display("FAIL b2b_first_data: got %h expected %h", rdata, mdl[7'h05]); end
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_reaccept: got %b expected 1", busy); end
    @(posedge clk);
    #1 rd = 1'b0;
    nb = 0;
    @(negedge clk);
    while (busy === 1'b1 && nb < LIMIT) begin
      nb++;
      @(negedge clk);
    end
    checks++; if (nb != LAT) begin errors++; $display("FAIL b2b_second_len: got %0d expected %0d", nb, LAT); end
    checks++; if (rdata !== mdl[7'h05]) begin errors++; $display("FAIL b2b_second_data: got %h expected %h", rdata, mdl[7'h05]); end
    last_rd = mdl[7'h05]; last_known = 1'b1;
  endtask

  task automatic test_random();
    int nb;
    logic [DW-1:0] q;
    bit            w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    for (int i = 0; i < 40; i++) begin
      w = ($urandom_range(0, 1) == 1);
      a = AW'($urandom_range(0, 15));
      d = DW'($urandom);
      access(w, a, d, nb, q);
      checks++; if (nb != LAT + 1) begin errors++; $display("FAIL rand_busy_len: op %0d got %0d expected %0d", i, nb, LAT + 1); end
      if (w) begin
        if (last_known) begin
          checks++; if (q !== last_rd) begin errors++; $display("FAIL rand_wr_rdata: op %0d got %h expected %h", i, q, last_rd); end
        end
        mdl[a] = d; known[a] = 1'b1;
      end else begin
        if (known[a]) begin
          checks++; if (q !== mdl[a]) begin errors++; $display("FAIL rand_rd_data: op %0d addr %h got %h expected %h", i, a, q, mdl[a]); end
          last_rd = mdl[a]; last_known = 1'b1;
        end else begin
          last_known = 1'b0;
        end
      end
    end
  endtask

  initial begin
    test_reset();
`ifdef MEM_CLEAR_EN
    test_clear();
`endif
    test_write_read();
    test_latency_long();
    test_illegal();
    test_mid_change();
    test_reset_access();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
